imm_decode_pipe: RTL and testbench
==================================

IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 The module SHALL take parameter DATA_WIDTH, default 20, as the instruction and immediate width; legal values are 20 to 32.
REQ-002 The module SHALL take parameter EN_PREFIX, default 1, which enables the immediate-prefix mode when set to 1.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; one clock domain, asynchronous, active-high.
REQ-005 in_valid / in_ready  in / out  1 / 1  upstream handshake.
REQ-006 in_instr  in  DATA_WIDTH  instruction word.
REQ-007 flush  in  1  discards the held output and any pending prefix.
REQ-008 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-009 out_opcode[3], out_funct[2], out_rd[5], out_rs1[5], out_rs2[5]  out  fields from instr[2:0], [4:3], [9:5], [14:10], [19:15].
REQ-010 out_imm  out  DATA_WIDTH  sign-extended immediate.
REQ-011 out_imm_type  out  3  immediate class: NONE, I, S, B or U.
REQ-012 out_prefixed / out_err  out  1 / 1  set when a prefix was merged / set when a prefix was discarded.

Function
REQ-013 The register fields SHALL be extracted unconditionally for every opcode.
REQ-014 The immediate SHALL be decoded from the opcode as follows:
- 010 and 011 (I-type): sign-extend instr[DW-1:DW-5].
- 100 (S-type): sign-extend instr[9:5].
- 101 (B-type): sign-extend instr[DW-1:5].
- 110 (U-type): {instr[DW-1:5], 5'b0}.
- Any other opcode: 0, with type NONE.
REQ-015 The block SHALL be a single-entry output register with in_ready = !out_valid || out_ready and an accept-to-output latency of one cycle.
REQ-016 While out_valid=1 and out_ready=0, all out_* SHALL be held stable.
REQ-017 When EN_PREFIX=1, opcode 111 SHALL be treated as a prefix:
- It is consumed when accepted and produces no output beat.
- It stores instr[DW-1:5] in the prefix register (width DW-5).
- It moves the FSM from IDLE to PREFIXED.
REQ-018 In the PREFIXED state, a second prefix SHALL replace the stored value, and the FSM SHALL stay in PREFIXED.
REQ-019 In the PREFIXED state, an accepted I-type or S-type instruction SHALL output imm = {prefix, base 5-bit field} (exactly DW bits) with out_prefixed=1, and the FSM SHALL return to IDLE.
REQ-020 In the PREFIXED state, any other accepted non-prefix instruction SHALL output its normal immediate with out_err=1, and the FSM SHALL return to IDLE.
REQ-021 When EN_PREFIX=0, opcode 111 SHALL be decoded as NONE with imm 0 and SHALL produce an output beat.
REQ-022 When a prefix is accepted in the same cycle that the held beat drains, out_valid SHALL go to 0 in the next cycle.
REQ-023 flush=1 SHALL force out_valid to 0 and the FSM to IDLE.
REQ-024 flush SHALL override a simultaneous accept, and the accepted word SHALL be discarded.

Reset
REQ-025 While rst=1, the block SHALL asynchronously apply these values:
- out_valid = 0.
- FSM = IDLE.
- Prefix register = 0.
- All out_* = 0, with out_imm_type = NONE.
REQ-026 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 Reset asserted mid-stall SHALL drop out_valid immediately, and the held beat SHALL be lost.

Structure
REQ-028 Package imm_pkg SHALL hold the following, and the module SHALL import it:
- the opcode localparams;
- the imm_type_e enum (NONE, I, S, B, U);
- the FSM state enum (IDLE, PREFIXED).
REQ-029 Combinational field and immediate extraction SHALL live in one sub-module, imm_extract, parameterised by DATA_WIDTH.
REQ-030 The sequential handshake, prefix FSM and output register SHALL live in imm_decode_pipe.

Verification (DATA_WIDTH=20, EN_PREFIX=1)
REQ-031 I-type: accept 0xF8002 with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFF, type I.
REQ-032 B-type: accept 0x80005 -> out_imm=0xFC000, type B, out_err=0.
REQ-033 Prefix merge: accept 0x02467, then 0x28002 -> exactly one beat with out_imm=0x02465 and out_prefixed=1.
REQ-034 Prefix error: accept 0x02467, then 0x80005 -> beat with out_imm=0xFC000 and out_err=1, and the FSM returns to IDLE.
REQ-035 Flush and stall:
- Accept 0x02467, pulse flush, then accept 0x28002 -> out_imm=0x00005, out_prefixed=0.
- Hold out_ready=0 for 3 cycles -> in_ready=0 and outputs unchanged.
REQ-036 Reset: assert rst mid-cycle while out_valid=1 -> out_valid=0 before the next clock edge, and all outputs are at their REQ-025 values.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate classes and prefix FSM states
// for the immediate decode pipeline.
package imm_pkg;

    localparam logic [2:0] OP_I0  = 3'b010;
    localparam logic [2:0] OP_I1  = 3'b011;
    localparam logic [2:0] OP_S   = 3'b100;
    localparam logic [2:0] OP_B   = 3'b101;
    localparam logic [2:0] OP_U   = 3'b110;
    localparam logic [2:0] OP_PFX = 3'b111;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4
    } imm_type_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_PREFIXED = 1'b1
    } state_e;

    typedef struct packed {
        logic [2:0] opcode;
        logic [1:0] funct;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } fields_t;

endpackage

// File: rtl/imm_extract.sv
// Purely combinational field and immediate extraction from one
// instruction word; prefix merging is left to the pipeline stage.
module imm_extract
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output fields_t               fields,
    output logic [DATA_WIDTH-1:0] imm,
    output imm_type_e             imm_type,
    output logic [4:0]            base_field,
    output logic [DATA_WIDTH-6:0] upper
);

    localparam int DW = DATA_WIDTH;

    always_comb begin
        fields.opcode = instr[2:0];
        fields.funct  = instr[4:3];
        fields.rd     = instr[9:5];
        fields.rs1    = instr[14:10];
        fields.rs2    = instr[19:15];
        upper         = instr[DW-1:5];
        base_field    = instr[DW-1:DW-5];
        imm           = '0;
        imm_type      = IMM_NONE;
        unique case (instr[2:0])
            OP_I0, OP_I1: begin
                imm      = {{(DW-5){instr[DW-1]}}, instr[DW-1:DW-5]};
                imm_type = IMM_I;
            end
            OP_S: begin
                // S-type's 5-bit base sits in the rd slot
                base_field = instr[9:5];
                imm        = {{(DW-5){instr[9]}}, instr[9:5]};
                imm_type   = IMM_S;
            end
            OP_B: begin
                imm      = {{5{instr[DW-1]}}, instr[DW-1:5]};
                imm_type = IMM_B;
            end
            OP_U: begin
                imm      = {instr[DW-1:5], 5'b0};
                imm_type = IMM_U;
            end
            default: begin
                imm      = '0;
                imm_type = IMM_NONE;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_pipe.sv
// Single-entry decode stage with valid/ready handshake and an optional
// prefix instruction that widens the next I/S immediate.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int EN_PREFIX  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_opcode,
    output logic [1:0]            out_funct,
    output logic [4:0]            out_rd,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [DATA_WIDTH-1:0] out_imm,
    output imm_type_e             out_imm_type,
    output logic                  out_prefixed,
    output logic                  out_err
);

    localparam int PW = DATA_WIDTH - 5;

    fields_t               x_fields;
    logic [DATA_WIDTH-1:0] x_imm;
    imm_type_e             x_type;
    logic [4:0]            x_base;
    logic [PW-1:0]         x_upper;

    state_e                state_q;
    state_e                state_d;
    logic [PW-1:0]         pfx_q;

    logic                  accept;
    logic                  is_pfx;
    logic                  load;

    logic [DATA_WIDTH-1:0] nxt_imm;
    logic                  nxt_prefixed;
    logic                  nxt_err;

    imm_extract #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_extract (
        .instr      (in_instr),
        .fields     (x_fields),
        .imm        (x_imm),
        .imm_type   (x_type),
        .base_field (x_base),
        .upper      (x_upper)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign is_pfx   = (EN_PREFIX != 0) && (x_fields.opcode == OP_PFX);
    assign load     = accept && !is_pfx && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            state_d = is_pfx ? ST_PREFIXED : ST_IDLE;
        end
    end

    always_comb begin
        nxt_imm      = x_imm;
        nxt_prefixed = 1'b0;
        nxt_err      = 1'b0;
        if (state_q == ST_PREFIXED) begin
            if (x_type == IMM_I || x_type == IMM_S) begin
                nxt_imm      = {pfx_q, x_base};
                nxt_prefixed = 1'b1;
            end else begin
                nxt_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pfx_q <= '0;
        end else if (flush) begin
            pfx_q <= '0;
        end else if (accept && is_pfx) begin
            pfx_q <= x_upper;
        end
    end

    // Flush wins over both a new accept and a pending drain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_opcode   <= '0;
            out_funct    <= '0;
            out_rd       <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_imm      <= '0;
            out_imm_type <= IMM_NONE;
            out_prefixed <= 1'b0;
            out_err      <= 1'b0;
        end else if (load) begin
            out_opcode   <= x_fields.opcode;
            out_funct    <= x_fields.funct;
            out_rd       <= x_fields.rd;
            out_rs1      <= x_fields.rs1;
            out_rs2      <= x_fields.rs2;
            out_imm      <= nxt_imm;
            out_imm_type <= x_type;
            out_prefixed <= nxt_prefixed;
            out_err      <= nxt_err;
        end
    end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed and random checks of imm_decode_pipe against an arithmetic
// reference model of the decode and prefix rules.
module tb_imm_decode_pipe;
    import imm_pkg::*;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_instr = '0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_opcode;
    logic [1:0]    out_funct;
    logic [4:0]    out_rd;
    logic [4:0]    out_rs1;
    logic [4:0]    out_rs2;
    logic [DW-1:0] out_imm;
    imm_type_e     out_imm_type;
    logic          out_prefixed;
    logic          out_err;

    imm_decode_pipe #(.DATA_WIDTH(DW), .EN_PREFIX(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_opcode   (out_opcode),
        .out_funct    (out_funct),
        .out_rd       (out_rd),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type),
        .out_prefixed (out_prefixed),
        .out_err      (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned opc, funct, rd, rs1, rs2, imm, typ;
        bit          pfx, err;
    } beat_t;

    int    vectors = 0;
    int    checks = 0;
    int    miscompares = 0;
    bit    m_valid = 0;
    bit    m_hp = 0;
    int unsigned m_pv = 0;
    beat_t m_beat;

    function automatic int unsigned sx5(int unsigned f);
        return (f >= 16) ? (f | 32'hFFFE0) : f;
    endfunction

    function automatic beat_t model_dec(int unsigned w, bit hp, int unsigned pv);
        beat_t b;
        int unsigned base;
        b.opc = w % 8;
        b.funct = (w >> 3) % 4;
        b.rd = (w >> 5) % 32;
        b.rs1 = (w >> 10) % 32;
        b.rs2 = (w >> 15) % 32;
        b.pfx = 0;
        b.err = 0;
        base = 0;
        b.imm = 0;
        b.typ = int'(IMM_NONE);
        if (b.opc == 2 || b.opc == 3) begin
            base = (w >> 15) % 32;
            b.imm = sx5(base) & 32'hFFFFF;
            b.typ = int'(IMM_I);
        end else if (b.opc == 4) begin
            base = (w >> 5) % 32;
            b.imm = sx5(base) & 32'hFFFFF;
            b.typ = int'(IMM_S);
        end else if (b.opc == 5) begin
            b.imm = (w >> 5) % 32768;
            if (b.imm >= 16384) b.imm = b.imm + 32'hF8000;
            b.typ = int'(IMM_B);
        end else if (b.opc == 6) begin
            b.imm = w & 32'hFFFE0;
            b.typ = int'(IMM_U);
        end
        if (hp) begin
            if (b.opc >= 2 && b.opc <= 4) begin
                b.imm = (pv * 32 + base) & 32'hFFFFF;
                b.pfx = 1;
            end else begin
                b.err = 1;
            end
        end
        return b;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("opcode", 32'(out_opcode), m_beat.opc);
            chk("funct", 32'(out_funct), m_beat.funct);
            chk("rd", 32'(out_rd), m_beat.rd);
            chk("rs1", 32'(out_rs1), m_beat.rs1);
            chk("rs2", 32'(out_rs2), m_beat.rs2);
            chk("imm", 32'(out_imm), m_beat.imm);
            chk("imm_type", 32'(out_imm_type), m_beat.typ);
            chk("prefixed", 32'(out_prefixed), 32'(m_beat.pfx));
            chk("err", 32'(out_err), 32'(m_beat.err));
        end
    endtask

    task automatic step(bit v, int unsigned w, bit rdy, bit fl);
        bit exp_ready;
        bit acc;
        bit nv;
        @(negedge clk);
        in_valid = v;
        in_instr = w[DW-1:0];
        out_ready = rdy;
        flush = fl;
        exp_ready = !m_valid || rdy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = v && exp_ready;
        nv = m_valid && !rdy;
        if (fl) begin
            nv = 0;
            m_hp = 0;
        end else if (acc && (w % 8) == 7) begin
            m_hp = 1;
            m_pv = (w >> 5) % 32768;
        end else if (acc) begin
            m_beat = model_dec(w, m_hp, m_pv);
            m_hp = 0;
            nv = 1;
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        vectors++;
        compare_all();
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_opcode"}, 32'(out_opcode), 0);
        chk({tag, "_funct"}, 32'(out_funct), 0);
        chk({tag, "_rd"}, 32'(out_rd), 0);
        chk({tag, "_rs1"}, 32'(out_rs1), 0);
        chk({tag, "_rs2"}, 32'(out_rs2), 0);
        chk({tag, "_imm"}, 32'(out_imm), 0);
        chk({tag, "_type"}, 32'(out_imm_type), 32'(IMM_NONE));
        chk({tag, "_pfx"}, 32'(out_prefixed), 0);
        chk({tag, "_err"}, 32'(out_err), 0);
    endtask

    initial begin
        #2;
        check_reset_values("rst_hold");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // I-type all-ones immediate
        step(1, 32'hF8002, 1, 0);
        chk("i_imm", 32'(out_imm), 32'hFFFFF);
        chk("i_type", 32'(out_imm_type), 32'(IMM_I));

        // B-type
        step(1, 32'h80005, 1, 0);
        chk("b_imm", 32'(out_imm), 32'hFC000);
        chk("b_err", 32'(out_err), 0);

        // prefix merge: prefix yields no beat
        step(1, 32'h02467, 1, 0);
        chk("pfx_nobeat", 32'(out_valid), 0);
        step(1, 32'h28002, 1, 0);
        chk("merge_imm", 32'(out_imm), 32'h02465);
        chk("merge_pfx", 32'(out_prefixed), 1);
        step(0, 0, 1, 0);
        chk("merge_one_beat", 32'(out_valid), 0);

        // prefix error then back to IDLE
        step(1, 32'h02467, 1, 0);
        step(1, 32'h80005, 1, 0);
        chk("perr_imm", 32'(out_imm), 32'hFC000);
        chk("perr_err", 32'(out_err), 1);
        step(1, 32'h28002, 1, 0);
        chk("perr_idle", 32'(out_prefixed), 0);

        // prefix then flush then I-type
        step(1, 32'h02467, 1, 0);
        step(0, 0, 1, 1);
        step(1, 32'h28002, 1, 0);
        chk("flush_imm", 32'(out_imm), 32'h00005);
        chk("flush_pfx", 32'(out_prefixed), 0);

        // flush beats a simultaneous accept
        step(1, 32'hF8002, 1, 1);
        chk("flush_acc", 32'(out_valid), 0);
        step(1, 32'h28002, 1, 0);

        // stall three cycles
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h80005, 0, 0);
            chk("stall_ready", 32'(in_ready), 0);
            chk("stall_imm", 32'(out_imm), 32'h00005);
        end

        // reset mid-stall
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        m_valid = 0;
        m_hp = 0;
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0);

        // prefix accepted while the held beat drains
        step(1, 32'h28002, 0, 0);
        step(1, 32'h02467, 1, 0);
        chk("pfx_drain", 32'(out_valid), 0);

        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, $urandom,
                 ($urandom % 4) != 0, ($urandom % 20) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
